ip_codma_task_sched: RTL and testbench

Multi-channel task scheduler in front of the CODMA main machine. Each of NUM_CH software channels queues (task pointer, status pointer) pairs into a private FIFO. The scheduler arbitrates round-robin among non-empty channels and launches one task at a time on the single DMA engine. It tracks completion or fault of that task and reports it per channel through a maskable, sticky interrupt.

---
 rtl/ip_codma_pkg.sv | 17 +
 rtl/ip_codma_task_fifo.sv | 61 ++++++
 rtl/ip_codma_task_sched.sv | 175 +++++++++++++++++
 tb/tb_ip_codma_task_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_pkg.sv
// Shared types and constants for the CODMA task scheduler.
// Default channel count lives here so benches and tops agree on widths.
package ip_codma_pkg;

  localparam int unsigned SCH_NUM_CH = 4;
  localparam int unsigned SCH_CH_W   = $clog2(SCH_NUM_CH);

  typedef enum logic [2:0] {
    SCH_IDLE      = 3'd0,
    SCH_START     = 3'd1,
    SCH_WAIT_BUSY = 3'd2,
    SCH_RUN       = 3'd3,
    SCH_DONE      = 3'd4,
    SCH_FAULT     = 3'd5
  } sched_state_t;

endpackage

// File: rtl/ip_codma_task_fifo.sv
// Per-channel FIFO of (task pointer, status pointer) pairs; flush beats push and pop.
// Head is visible combinationally on data_o; full/empty come from the registered count.
module ip_codma_task_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ip_codma_task_sched.sv
// Round-robin scheduler launching one queued CODMA task at a time and reporting its outcome.
// Submit-to-start is 2 cycles; sub_ready_o drops only when a channel FIFO is full.
module ip_codma_task_sched
  import ip_codma_pkg::*;
#(
  parameter int unsigned NUM_CH        = SCH_NUM_CH,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [NUM_CH-1:0]           sub_valid_i,
  output logic [NUM_CH-1:0]           sub_ready_o,
  input  logic [NUM_CH-1:0][31:0]     sub_task_ptr_i,
  input  logic [NUM_CH-1:0][31:0]     sub_status_ptr_i,
  input  logic [NUM_CH-1:0]           abort_i,
  output logic                        start_o,
  output logic                        stop_o,
  output logic [31:0]                 task_pointer_o,
  output logic [31:0]                 status_pointer_o,
  input  logic                        busy_i,
  input  logic                        irq_i,
  input  logic                        dma_error_i,
  output logic                        active_o,
  output logic [$clog2(NUM_CH)-1:0]   active_ch_o,
  output logic [NUM_CH-1:0]           done_o,
  output logic [NUM_CH-1:0]           fault_o,
  input  logic [NUM_CH-1:0]           irq_mask_i,
  input  logic [NUM_CH-1:0]           irq_clr_i,
  output logic [NUM_CH-1:0]           pending_o,
  output logic                        irq_o
);
  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned TW   = $clog2(START_TIMEOUT + 1);

  sched_state_t      state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d, active_ch_q, active_ch_d, grant_ch;
  logic [31:0]       task_ptr_q, task_ptr_d, status_ptr_q, status_ptr_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic              irq_q, irq_d;
  logic [NUM_CH-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, req, ch_onehot;
  logic [63:0]       fifo_head [NUM_CH];
  logic              grant_vld, launch, abort_act, set_done, set_fault;
  int                idx;

  assign fifo_push = sub_valid_i & ~fifo_full & ~abort_i;
  // A channel being aborted this cycle must not be granted a head that is about to vanish.
  assign req       = ~fifo_empty & ~abort_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    ip_codma_task_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (fifo_push[c]),
      .pop_i     (fifo_pop[c]),
      .flush_i   (abort_i[c]),
      .data_i    ({sub_task_ptr_i[c], sub_status_ptr_i[c]}),
      .data_o    (fifo_head[c]),
      .full_o    (fifo_full[c]),
      .empty_o   (fifo_empty[c])
    );
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      idx = (int'(last_grant_q) + i) % int'(NUM_CH);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  assign launch    = (state_q == SCH_IDLE) & grant_vld & ~busy_i;
  assign fifo_pop  = launch ? (NUM_CH'(1) << grant_ch) : '0;
  assign ch_onehot = NUM_CH'(1) << active_ch_q;
  assign abort_act = abort_i[active_ch_q];

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    active_ch_d  = active_ch_q;
    task_ptr_d   = task_ptr_q;
    status_ptr_d = status_ptr_q;
    start_o      = 1'b0;
    stop_o       = 1'b0;
    set_done     = 1'b0;
    set_fault    = 1'b0;
    unique case (state_q)
      SCH_IDLE: if (launch) begin
        last_grant_d = grant_ch;
        active_ch_d  = grant_ch;
        task_ptr_d   = fifo_head[grant_ch][63:32];
        status_ptr_d = fifo_head[grant_ch][31:0];
        state_d      = SCH_START;
      end
      SCH_START: begin
        start_o = 1'b1;
        timer_d = '0;
        err_d   = 1'b0;
        state_d = SCH_WAIT_BUSY;
      end
      SCH_WAIT_BUSY: begin
        if (abort_act)                            state_d = SCH_FAULT;
        else if (busy_i)                          state_d = SCH_RUN;
        else if (timer_q == TW'(START_TIMEOUT-1)) state_d = SCH_FAULT;
        else                                      timer_d = timer_q + 1'b1;
      end
      SCH_RUN: begin
        if (abort_act) state_d = SCH_FAULT;
        else begin
          if (dma_error_i) err_d = 1'b1;
          if (irq_i)       state_d = SCH_DONE;
        end
      end
      SCH_DONE: begin
        set_done  = ~err_q;
        set_fault = err_q;
        state_d   = SCH_IDLE;
      end
      SCH_FAULT: begin
        stop_o    = 1'b1;
        set_fault = 1'b1;
        state_d   = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  assign done_o    = set_done  ? ch_onehot : '0;
  assign fault_o   = set_fault ? ch_onehot : '0;
  // Same-cycle set beats write-1-to-clear.
  assign pending_d = (pending_q & ~irq_clr_i) | done_o | fault_o;
  assign irq_d     = |(pending_q & irq_mask_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= SCH_IDLE;
      timer_q      <= '0;
      err_q        <= 1'b0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      active_ch_q  <= '0;
      task_ptr_q   <= '0;
      status_ptr_q <= '0;
      pending_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      active_ch_q  <= active_ch_d;
      task_ptr_q   <= task_ptr_d;
      status_ptr_q <= status_ptr_d;
      pending_q    <= pending_d;
      irq_q        <= irq_d;
    end
  end

  assign sub_ready_o      = ~fifo_full;
  assign task_pointer_o   = task_ptr_q;
  assign status_pointer_o = status_ptr_q;
  assign active_o         = (state_q != SCH_IDLE);
  assign active_ch_o      = active_ch_q;
  assign pending_o        = pending_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_ip_codma_task_sched.sv
// Directed bench for ip_codma_task_sched: launch table plus hand sequences for
// FIFO-full, start timeout, abort and pending/irq behaviour.
module tb_ip_codma_task_sched;
  import ip_codma_pkg::*;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic [3:0]        sub_valid_i = '0;
  logic [3:0]        sub_ready_o;
  logic [3:0][31:0]  sub_task_ptr_i = '0;
  logic [3:0][31:0]  sub_status_ptr_i = '0;
  logic [3:0]        abort_i = '0;
  logic              start_o, stop_o;
  logic [31:0]       task_pointer_o, status_pointer_o;
  logic              busy_i = 1'b0, irq_i = 1'b0, dma_error_i = 1'b0;
  logic              active_o;
  logic [SCH_CH_W-1:0] active_ch_o;
  logic [3:0]        done_o, fault_o;
  logic [3:0]        irq_mask_i = '0, irq_clr_i = '0;
  logic [3:0]        pending_o;
  logic              irq_o;

  int checks = 0;
  int failures = 0;

  ip_codma_task_sched #(.NUM_CH(4), .FIFO_DEPTH(4), .START_TIMEOUT(16)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .sub_valid_i(sub_valid_i), .sub_ready_o(sub_ready_o),
    .sub_task_ptr_i(sub_task_ptr_i), .sub_status_ptr_i(sub_status_ptr_i),
    .abort_i(abort_i), .start_o(start_o), .stop_o(stop_o),
    .task_pointer_o(task_pointer_o), .status_pointer_o(status_pointer_o),
    .busy_i(busy_i), .irq_i(irq_i), .dma_error_i(dma_error_i),
    .active_o(active_o), .active_ch_o(active_ch_o),
    .done_o(done_o), .fault_o(fault_o),
    .irq_mask_i(irq_mask_i), .irq_clr_i(irq_clr_i),
    .pending_o(pending_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    int          ch;
    logic [31:0] tp;
    logic [31:0] sp;
    bit          err;
    logic [3:0]  exp_done;
    logic [3:0]  exp_fault;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    sub_valid_i = '0; abort_i = '0; busy_i = 0; irq_i = 0; dma_error_i = 0; irq_clr_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  // Engine model: wait for a launch, raise busy in the following cycle, finish with irq.
  task automatic serve(input string nm, input int ch, input logic [31:0] tp, input logic [31:0] sp,
                       input bit err, input logic [3:0] exp_done, input logic [3:0] exp_fault,
                       input logic [3:0] clr);
    int n = 0;
    while (!start_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({nm, " start_seen"}, 32'(start_o), 32'd1);
    chk({nm, " active_ch"}, 32'(active_ch_o), 32'(ch));
    chk({nm, " task_ptr"}, task_pointer_o, tp);
    chk({nm, " status_ptr"}, status_pointer_o, sp);
    @(negedge clk_i); busy_i = 1'b1;
    @(negedge clk_i);
    if (err) begin
      dma_error_i = 1'b1;
      @(negedge clk_i);
      dma_error_i = 1'b0;
    end
    repeat (3) @(negedge clk_i);
    irq_i = 1'b1; busy_i = 1'b0;
    @(negedge clk_i);
    irq_i = 1'b0; irq_clr_i = clr;
    chk({nm, " done"}, 32'(done_o), 32'(exp_done));
    chk({nm, " fault"}, 32'(fault_o), 32'(exp_fault));
    @(negedge clk_i);
    irq_clr_i = '0;
  endtask

  task automatic expect_quiet(input string nm);
    bit seen = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (start_o || active_o) seen = 1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 32'h1000, 32'h2000, 1'b0, 4'b0001, 4'b0000};
    vecs[1] = '{1, 32'h1010, 32'h2010, 1'b0, 4'b0010, 4'b0000};
    vecs[2] = '{2, 32'h1020, 32'h2020, 1'b0, 4'b0100, 4'b0000};
    vecs[3] = '{3, 32'h1030, 32'h2030, 1'b0, 4'b1000, 4'b0000};
    vecs[4] = '{0, 32'h1001, 32'h2001, 1'b0, 4'b0001, 4'b0000};
    vecs[5] = '{1, 32'h1011, 32'h2011, 1'b1, 4'b0000, 4'b0010};
    vecs[6] = '{2, 32'h1021, 32'h2021, 1'b0, 4'b0100, 4'b0000};
    vecs[7] = '{3, 32'h1031, 32'h2031, 1'b0, 4'b1000, 4'b0000};

    do_reset();
    chk("rst start", 32'(start_o), 0);
    chk("rst stop", 32'(stop_o), 0);
    chk("rst active", 32'(active_o), 0);
    chk("rst pending", 32'(pending_o), 0);
    chk("rst irq", 32'(irq_o), 0);
    chk("rst ready", 32'(sub_ready_o), 32'hF);
    chk("rst task_ptr", task_pointer_o, 0);

    // Single task on ch0 with exact timing.
    irq_mask_i = 4'b0001;
    sub_valid_i = 4'b0001; sub_task_ptr_i[0] = 32'h100; sub_status_ptr_i[0] = 32'h200;
    @(posedge clk_i);
    @(negedge clk_i); sub_valid_i = '0;
    chk("A start T+1", 32'(start_o), 0);
    @(negedge clk_i);
    chk("A start T+2", 32'(start_o), 1);
    chk("A task_ptr", task_pointer_o, 32'h100);
    chk("A status_ptr", status_pointer_o, 32'h200);
    @(negedge clk_i); busy_i = 1'b1;
    @(negedge clk_i);
    repeat (9) @(negedge clk_i);
    irq_i = 1'b1; busy_i = 1'b0;
    @(negedge clk_i); irq_i = 1'b0;
    chk("A done", 32'(done_o), 32'b0001);
    chk("A fault", 32'(fault_o), 0);
    chk("A task_ptr held", task_pointer_o, 32'h100);
    @(negedge clk_i);
    chk("A pending", 32'(pending_o), 32'b0001);
    chk("A irq early", 32'(irq_o), 0);
    @(negedge clk_i);
    chk("A irq", 32'(irq_o), 1);
    irq_clr_i = 4'b0001;
    @(negedge clk_i); irq_clr_i = '0;
    chk("A pending clr", 32'(pending_o), 0);
    @(negedge clk_i);
    chk("A irq clr", 32'(irq_o), 0);

    // Round-robin over all channels, two tasks each, from a fresh reset.
    do_reset();
    irq_mask_i = 4'hF;
    sub_valid_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      sub_task_ptr_i[c] = 32'h1000 + 32'(c * 16);
      sub_status_ptr_i[c] = 32'h2000 + 32'(c * 16);
    end
    @(negedge clk_i);
    for (int c = 0; c < 4; c++) begin
      sub_task_ptr_i[c] = 32'h1001 + 32'(c * 16);
      sub_status_ptr_i[c] = 32'h2001 + 32'(c * 16);
    end
    @(negedge clk_i); sub_valid_i = '0;
    for (int i = 0; i < 8; i++)
      serve($sformatf("B[%0d]", i), vecs[i].ch, vecs[i].tp, vecs[i].sp, vecs[i].err,
            vecs[i].exp_done, vecs[i].exp_fault, 4'b0000);
    @(negedge clk_i);
    chk("B pending", 32'(pending_o), 32'hF);
    chk("B irq", 32'(irq_o), 1);
    irq_clr_i = 4'hF;
    @(negedge clk_i); irq_clr_i = '0;
    chk("B pending clr", 32'(pending_o), 0);

    // Fill ch1 while the engine is busy so nothing is popped.
    busy_i = 1'b1;
    sub_valid_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      sub_task_ptr_i[1] = 32'h3000 + 32'(i);
      sub_status_ptr_i[1] = 32'h3100 + 32'(i);
      @(negedge clk_i);
    end
    chk("C ready full", 32'(sub_ready_o[1]), 0);
    sub_task_ptr_i[1] = 32'h3004; sub_status_ptr_i[1] = 32'h3104;
    @(negedge clk_i); sub_valid_i = '0;
    chk("C ready still full", 32'(sub_ready_o[1]), 0);
    busy_i = 1'b0;
    @(negedge clk_i);
    chk("C start after release", 32'(start_o), 1);
    chk("C ready after pop", 32'(sub_ready_o[1]), 1);
    for (int i = 0; i < 4; i++)
      serve($sformatf("C[%0d]", i), 1, 32'h3000 + 32'(i), 32'h3100 + 32'(i), 1'b0,
            4'b0010, 4'b0000, 4'b0000);
    expect_quiet("C fifth dropped");
    irq_clr_i = 4'hF;
    @(negedge clk_i); irq_clr_i = '0;

    // Start timeout on ch3: engine never goes busy.
    sub_valid_i = 4'b1000; sub_task_ptr_i[3] = 32'h4000; sub_status_ptr_i[3] = 32'h4100;
    @(negedge clk_i); sub_valid_i = '0;
    begin
      int n = 0;
      bit early = 0;
      while (!start_o && n < 50) begin
        @(negedge clk_i);
        n++;
      end
      chk("D start_seen", 32'(start_o), 1);
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk_i);
        if (stop_o || fault_o != 0) early = 1;
      end
      chk("D no early stop", 32'(early), 0);
      @(negedge clk_i);
      chk("D stop", 32'(stop_o), 1);
      chk("D fault", 32'(fault_o), 32'b1000);
      chk("D done", 32'(done_o), 0);
      @(negedge clk_i);
      chk("D idle", 32'(active_o), 0);
    end
    irq_clr_i = 4'hF;
    @(negedge clk_i); irq_clr_i = '0;

    // Abort ch2 mid-run with 3 entries still queued; ch3 must be next.
    irq_mask_i = 4'b0100;
    busy_i = 1'b1;
    sub_valid_i = 4'b1100;
    sub_task_ptr_i[3] = 32'h6000; sub_status_ptr_i[3] = 32'h6100;
    for (int i = 0; i < 4; i++) begin
      sub_task_ptr_i[2] = 32'h5000 + 32'(i);
      sub_status_ptr_i[2] = 32'h5100 + 32'(i);
      @(negedge clk_i);
      sub_valid_i = 4'b0100;
    end
    sub_valid_i = '0; busy_i = 1'b0;
    begin
      int n = 0;
      while (!start_o && n < 50) begin
        @(negedge clk_i);
        n++;
      end
    end
    chk("E start ch", 32'(active_ch_o), 2);
    chk("E task_ptr", task_pointer_o, 32'h5000);
    @(negedge clk_i); busy_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i); abort_i = 4'b0100;
    @(negedge clk_i); abort_i = '0; busy_i = 1'b0;
    chk("E stop", 32'(stop_o), 1);
    chk("E fault", 32'(fault_o), 32'b0100);
    chk("E done", 32'(done_o), 0);
    serve("E ch3", 3, 32'h6000, 32'h6100, 1'b0, 4'b1000, 4'b0000, 4'b1000);
    expect_quiet("E ch2 flushed");
    chk("E pending set wins", 32'(pending_o), 32'b1100);
    chk("E irq", 32'(irq_o), 1);
    irq_clr_i = 4'b0100;
    @(negedge clk_i); irq_clr_i = '0;
    chk("E pending clr2", 32'(pending_o), 32'b1000);
    @(negedge clk_i);
    chk("E irq clr", 32'(irq_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
